sync_edge_filter: RTL and testbench

- Consumes the single-bit output of the multi-flop bit synchroniser, already in the `clck` domain.
- Rejects glitches shorter than a programmable number of cycles and produces a clean filtered level.
- Emits one-cycle rising and falling pulses on each accepted transition.
- Keeps a saturating count of accepted rising edges for the control/register block.

---
 rtl/sync_edge_filter_if.sv | 32 +++
 rtl/sync_edge_filter.sv | 127 ++++++++++++
 tb/tb_sync_edge_filter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sync_edge_filter_if.sv
// Signal bundle for sync_edge_filter: the synchronised input level, the
// controls and the filtered outputs. clck/rst stay outside the bundle.
//
// There is no valid/ready handshake on this bundle. sync_in, enable and
// clr_cnt are sampled on every rising clck edge. The outputs are registered
// and are valid in every cycle. rise_pulse and fall_pulse are the
// per-cycle "event present" markers for accepted transitions.
interface sync_edge_filter_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 sync_in;
  logic                 enable;
  logic                 clr_cnt;
  logic                 filt_out;
  logic                 rise_pulse;
  logic                 fall_pulse;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic                 cnt_sat;
  logic [1:0]           fsm_state;

  // Driver side: stimulus or upstream logic.
  modport master (
    output sync_in, enable, clr_cnt,
    input  filt_out, rise_pulse, fall_pulse, edge_cnt, cnt_sat, fsm_state
  );

  // Filter side.
  modport slave (
    input  sync_in, enable, clr_cnt,
    output filt_out, rise_pulse, fall_pulse, edge_cnt, cnt_sat, fsm_state
  );
endinterface

// File: rtl/sync_edge_filter.sv
// Glitch filter for an already-synchronised level. A new level is accepted
// only after FILT_CYCLES consecutive sampled cycles at that level. Each
// accepted transition produces a one-cycle rise or fall pulse. Accepted
// rising edges are counted in a saturating counter, and a sticky flag
// records any increment attempted while the counter was at its maximum.
module sync_edge_filter #(
  parameter int FILT_CYCLES = 4,
  parameter int CNT_WIDTH   = 8
) (
  input logic             clck,
  input logic             rst,
  sync_edge_filter_if.slave bus
);
  localparam int SW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [SW-1:0]        STAB_ONE  = SW'(1);
  localparam logic [SW-1:0]        STAB_LAST = SW'(FILT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

  state_t               state;
  logic [SW-1:0]        stab_cnt;
  logic                 filt_q;
  logic                 rise_q;
  logic                 fall_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 sat_q;
  logic                 accept_rise;

  // A rising transition is accepted on this edge (drives the counter update).
  assign accept_rise = bus.enable && (state == CHECK_HI) && bus.sync_in &&
                       (stab_cnt == STAB_LAST);

  // Qualification FSM with registered level and pulse outputs.
  always_ff @(posedge clck) begin
    if (rst) begin
      state    <= STABLE_LO;
      stab_cnt <= '0;
      filt_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (!bus.enable) begin
        // Drop any partial qualification and park in the stable state
        // that matches the level currently presented.
        state    <= filt_q ? STABLE_HI : STABLE_LO;
        stab_cnt <= '0;
      end else begin
        case (state)
          STABLE_LO: begin
            if (bus.sync_in) begin
              state    <= CHECK_HI;
              stab_cnt <= STAB_ONE;
            end
          end
          CHECK_HI: begin
            if (!bus.sync_in) begin
              state    <= STABLE_LO;
              stab_cnt <= '0;
            end else if (stab_cnt == STAB_LAST) begin
              state    <= STABLE_HI;
              stab_cnt <= '0;
              filt_q   <= 1'b1;
              rise_q   <= 1'b1;
            end else begin
              stab_cnt <= stab_cnt + STAB_ONE;
            end
          end
          STABLE_HI: begin
            if (!bus.sync_in) begin
              state    <= CHECK_LO;
              stab_cnt <= STAB_ONE;
            end
          end
          CHECK_LO: begin
            if (bus.sync_in) begin
              state    <= STABLE_HI;
              stab_cnt <= '0;
            end else if (stab_cnt == STAB_LAST) begin
              state    <= STABLE_LO;
              stab_cnt <= '0;
              filt_q   <= 1'b0;
              fall_q   <= 1'b1;
            end else begin
              stab_cnt <= stab_cnt + STAB_ONE;
            end
          end
          default: begin
            state    <= STABLE_LO;
            stab_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Saturating rising-edge counter. When clr_cnt and an accepted rising
  // edge fall on the same edge, the clear wins and the increment is lost.
  always_ff @(posedge clck) begin
    if (rst || bus.clr_cnt) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (accept_rise) begin
      if (cnt_q == CNT_MAX) begin
        sat_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.filt_out   = filt_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.edge_cnt   = cnt_q;
  assign bus.cnt_sat    = sat_q;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed bench for sync_edge_filter (FILT_CYCLES=4, CNT_WIDTH=4).
// The stimulus pushes each expected pulse event, including the clock edge
// on which it must appear, into a queue. A monitor pops the queue on every
// pulse the DUT shows and compares the event against the popped entry.
module tb_sync_edge_filter;
  localparam int FILT = 4;
  localparam int CW   = 4;

  typedef struct packed {
    logic [31:0]   cyc;
    logic          rise;
    logic          fall;
    logic          filt;
    logic [CW-1:0] cnt;
    logic          sat;
  } exp_t;

  logic clck;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  sync_edge_filter_if #(.CNT_WIDTH(CW)) bus ();

  sync_edge_filter #(.FILT_CYCLES(FILT), .CNT_WIDTH(CW)) dut (
    .clck (clck),
    .rst  (rst),
    .bus  (bus)
  );

  // Clock and edge counter.
  initial clck = 1'b0;
  always #5 clck = ~clck;
  always @(posedge clck) cyc <= cyc + 1;

  // Apply one input vector; it is sampled by the next rising edge.
  task automatic drive(input logic r, input logic si, input logic en, input logic cc);
    @(negedge clck);
    rst         = r;
    bus.sync_in = si;
    bus.enable  = en;
    bus.clr_cnt = cc;
  endtask

  task automatic run(input logic si, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, si, 1'b1, 1'b0);
  endtask

  // Expect a pulse on the edge 'ahead' sampling edges from the vector just driven.
  task automatic push_ev(input int ahead, input logic r, input logic [CW-1:0] c, input logic s);
    exp_t e;
    e.cyc  = 32'(cyc + ahead);
    e.rise = r;
    e.fall = ~r;
    e.filt = r;
    e.cnt  = c;
    e.sat  = s;
    exp_q.push_back(e);
  endtask

  // One full accepted rise followed by one full accepted fall.
  task automatic rise_fall(input logic [CW-1:0] c, input logic s);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    push_ev(FILT, 1'b1, c, s);
    run(1'b1, FILT - 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    push_ev(FILT, 1'b0, c, s);
    run(1'b0, FILT - 1);
  endtask

  // Level check of the outputs left by the previous sampled vector.
  task automatic check_now(input string name, input logic f, input logic [CW-1:0] c, input logic s);
    logic [CW+1:0] got, want;
    got  = {bus.filt_out, bus.edge_cnt, bus.cnt_sat};
    want = {f, c, s};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: filt/cnt/sat got %b/%0d/%b want %b/%0d/%b",
               name, got[CW+1], got[CW:1], got[0], f, c, s);
    end
  endtask

  task automatic check_reset(input string name);
    logic [CW+5:0] got;
    got = {bus.filt_out, bus.rise_pulse, bus.fall_pulse, bus.edge_cnt, bus.cnt_sat, bus.fsm_state};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL %s: outputs got %b want all zero", name, got);
    end
  endtask

  // Monitor: every pulse must match the next expected event.
  always @(negedge clck) begin
    exp_t e, g;
    if (bus.rise_pulse === 1'b1 || bus.fall_pulse === 1'b1) begin
      total++;
      g.cyc  = 32'(cyc);
      g.rise = bus.rise_pulse;
      g.fall = bus.fall_pulse;
      g.filt = bus.filt_out;
      g.cnt  = bus.edge_cnt;
      g.sat  = bus.cnt_sat;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: edge=%0d rise=%b fall=%b filt=%b cnt=%0d, none expected",
                 g.cyc, g.rise, g.fall, g.filt, g.cnt);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL pulse_event: got edge=%0d r=%b f=%b filt=%b cnt=%0d sat=%b want edge=%0d r=%b f=%b filt=%b cnt=%0d sat=%b",
                   g.cyc, g.rise, g.fall, g.filt, g.cnt, g.sat,
                   e.cyc, e.rise, e.fall, e.filt, e.cnt, e.sat);
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.sync_in = 1'b1;
    bus.enable  = 1'b1;
    bus.clr_cnt = 1'b0;

    // Reset held with sync_in high, then release and qualify.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check_reset("reset_hold");
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check_reset("reset_last");
    push_ev(FILT, 1'b1, 4'd1, 1'b0);
    run(1'b1, FILT - 1 + 2);
    check_now("after_first_rise", 1'b1, 4'd1, 1'b0);

    // Falling edge.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    push_ev(FILT, 1'b0, 4'd1, 1'b0);
    run(1'b0, FILT - 1 + 2);
    check_now("after_fall", 1'b0, 4'd1, 1'b0);

    // Short glitch: 3 high cycles are rejected.
    run(1'b1, 3);
    run(1'b0, 3);
    check_now("glitch_rejected", 1'b0, 4'd1, 1'b0);

    // One low cycle inside a run of six highs restarts qualification.
    run(1'b1, 2);
    run(1'b0, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    push_ev(FILT, 1'b1, 4'd2, 1'b0);
    run(1'b1, FILT - 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    push_ev(FILT, 1'b0, 4'd2, 1'b0);
    run(1'b0, FILT - 1);

    // Saturation: clear, then 16 accepted rising edges.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      rise_fall((i > 15) ? 4'd15 : CW'(i), (i == 16));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check_now("saturated", 1'b0, 4'd15, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check_now("clr_after_sat", 1'b0, 4'd0, 1'b0);

    // Clear colliding with an accepted rise at edge_cnt=5.
    for (int i = 1; i <= 5; i++) rise_fall(CW'(i), 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    push_ev(FILT, 1'b1, 4'd0, 1'b0);
    run(1'b1, FILT - 2);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check_now("clr_collision", 1'b1, 4'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    push_ev(FILT, 1'b0, 4'd0, 1'b0);
    run(1'b0, FILT - 1);

    // Enable drop discards a partial qualification.
    run(1'b1, 2);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    push_ev(FILT, 1'b1, 4'd1, 1'b0);
    run(1'b1, FILT - 1);
    check_now("enable_restart_wait", 1'b0, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check_now("enable_restart_done", 1'b1, 4'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    push_ev(FILT, 1'b0, 4'd1, 1'b0);
    run(1'b0, FILT - 1);

    // Reset mid-qualification behaves the same and clears the count.
    run(1'b1, 2);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check_reset("reset_mid_qual");
    push_ev(FILT, 1'b1, 4'd1, 1'b0);
    run(1'b1, FILT - 1 + 1);
    check_now("reset_restart_done", 1'b1, 4'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    push_ev(FILT, 1'b0, 4'd1, 1'b0);
    run(1'b0, FILT - 1 + 3);

    // Every expected pulse must have been seen.
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses: %0d expected events left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
